// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Used by the fetch unit, its prefetch buffer and the testbench.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/gnt/rvalid port, one outstanding request.
// master = fetch unit, slave = instruction memory.
interface fetch_if;

  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid;
  logic [31:0] IMemRData;

  modport master (
    output IMemReq, IMemAddr,
    input  IMemGnt, IMemRValid, IMemRData
  );

  modport slave (
    input  IMemReq, IMemAddr,
    output IMemGnt, IMemRValid, IMemRData
  );

endinterface

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, instr}; registered, head visible the cycle after push.
// Flush beats push and pop; push into a full buffer without a pop is dropped.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_dat,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop & ~flush & (count_q != '0);
    do_push  = push & ~flush & ((count_q != CW'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns FetchPC, one-outstanding imem port and a prefetch buffer.
// Grant N, rvalid N+k, ValidF N+k+1; Stall holds the head, issue stops when buffer slots are reserved.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  fetch_if.master     imem,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_pending_q, drop_pending_d;

  logic [CW-1:0] buf_count;
  fetch_entry_t  buf_head, push_dat;
  logic          pop, push, issue, gnt, rsp_vld;
  logic [OW-1:0] occupancy;

  always_comb begin
    ValidF    = (buf_count != '0);
    pop       = ValidF & ~Stall & ~PCSrcE;
    rsp_vld   = imem.IMemRValid & outstanding_q;
    // Entries held after this cycle plus the one still in flight.
    occupancy = OW'(buf_count) + OW'(outstanding_q) - OW'(pop);
    issue     = ~PCSrcE & ~drop_pending_q & (~outstanding_q | imem.IMemRValid)
              & (occupancy < OW'(BUF_DEPTH));
    gnt       = issue & imem.IMemGnt;
    push      = rsp_vld & ~drop_pending_q & ~PCSrcE;
    push_dat  = '{pc: req_addr_q, instr: imem.IMemRData};
  end

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    req_addr_d     = req_addr_q;
    outstanding_d  = outstanding_q;
    drop_pending_d = drop_pending_q;
    if (rsp_vld) begin
      outstanding_d  = 1'b0;
      drop_pending_d = 1'b0;
    end
    if (PCSrcE) begin
      fetch_pc_d = PCTargetE;
      if (outstanding_q & ~rsp_vld) drop_pending_d = 1'b1;
    end else if (gnt) begin
      fetch_pc_d    = pc_plus4(fetch_pc_q);
      req_addr_d    = fetch_pc_q;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q     <= RESET_PC;
      req_addr_q     <= RESET_PC;
      outstanding_q  <= 1'b0;
      drop_pending_q <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      req_addr_q     <= req_addr_d;
      outstanding_q  <= outstanding_d;
      drop_pending_q <= drop_pending_d;
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (PCSrcE),
    .head_dat (buf_head),
    .count    (buf_count)
  );

  // Request is masked while reset is held so the port is quiet during reset.
  assign imem.IMemReq  = issue & rst_n;
  assign imem.IMemAddr = fetch_pc_q;

  always_comb begin
    InstrF   = ValidF ? buf_head.instr : NOP_INSTR;
    PCF      = ValidF ? buf_head.pc    : fetch_pc_q;
    PCPlus4F = pc_plus4(PCF);
  end

  unexpected_rvalid_a : assert property (
    @(posedge clk) disable iff (!rst_n) imem.IMemRValid |-> outstanding_q
  ) else $warning("fetch_unit: IMemRValid with no outstanding request, ignored");

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-randomised memory model plus a program-order
// scoreboard (next expected fetch address / next expected consumed PC).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Stall = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF;

  fetch_if imem();

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem(imem), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int k_lo = 1, k_hi = 1;
  int gnt_pct = 100;
  int rsp_due = -1;
  logic [31:0] rsp_addr = '0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] fetch_exp = RST_PC;
  logic        s_req, s_gnt, s_vld;
  logic [31:0] s_addr, s_pcf;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive at posedge+1, sample and score at negedge.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
    Stall = st;
    PCSrcE = rd;
    PCTargetE = tgt;
    imem.IMemGnt = ($urandom_range(99) < gnt_pct);
    if (rsp_due == cyc) begin
      imem.IMemRValid = 1'b1;
      imem.IMemRData  = mem_word(rsp_addr);
      rsp_due = -1;
    end else begin
      imem.IMemRValid = 1'b0;
      imem.IMemRData  = $urandom;
    end
    @(negedge clk);
    s_req = imem.IMemReq;
    s_gnt = imem.IMemReq & imem.IMemGnt;
    s_addr = imem.IMemAddr;
    s_vld = ValidF;
    s_pcf = PCF;
    tests_run++;
    if (ValidF === 1'b1) begin
      if (PCF !== exp_pc || InstrF !== mem_word(exp_pc) || PCPlus4F !== exp_pc + 32'd4) begin
        tests_failed++;
        $display("FAIL head cyc=%0d: pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h",
                 cyc, PCF, InstrF, PCPlus4F, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
      end
    end else if (InstrF !== NOP_INSTR || PCF !== fetch_exp || PCPlus4F !== fetch_exp + 32'd4 || ValidF !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty cyc=%0d: vld=%b instr=%h pc=%h pc4=%h, want instr=%h pc=%h",
               cyc, ValidF, InstrF, PCF, PCPlus4F, NOP_INSTR, fetch_exp);
    end
    if (ValidF === 1'b1 && !st && !rd) exp_pc = exp_pc + 32'd4;
    if (rd) begin
      tests_run++;
      if (s_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL redirect_req cyc=%0d: req=%b, want 0", cyc, s_req);
      end
      exp_pc = tgt;
      fetch_exp = tgt;
    end else if (s_gnt === 1'b1) begin
      tests_run++;
      if (s_addr !== fetch_exp) begin
        tests_failed++;
        $display("FAIL grant_addr cyc=%0d: addr=%h, want %h", cyc, s_addr, fetch_exp);
      end
      fetch_exp = fetch_exp + 32'd4;
      rsp_due = cyc + int'($urandom_range(k_hi, k_lo));
      rsp_addr = s_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    Stall = 1'b0;
    PCSrcE = 1'b0;
    imem.IMemGnt = 1'b0;
    imem.IMemRValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = RST_PC;
    fetch_exp = RST_PC;
    rsp_due = -1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    do begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end while (s_gnt !== 1'b1 && n < 20);
    tests_run++;
    if (s_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_grant_timeout: no grant in %0d cycles, want one", tag, n);
    end
  endtask

  task automatic wait_valid_pc(input string tag, input logic [31:0] want);
    int n = 0;
    do begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end while (s_vld !== 1'b1 && n < 30);
    tests_run++;
    if (s_vld !== 1'b1 || s_pcf !== want) begin
      tests_failed++;
      $display("FAIL %s_first_valid: vld=%b pc=%h, want vld=1 pc=%h", tag, s_vld, s_pcf, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem.IMemReq !== 1'b0 || ValidF !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: req=%b vld=%b, want 0 0", imem.IMemReq, ValidF);
    end
    tests_run++;
    if (InstrF !== NOP_INSTR || PCF !== RST_PC || PCPlus4F !== RST_PC + 32'd4) begin
      tests_failed++;
      $display("FAIL reset_out: instr=%h pc=%h pc4=%h, want %h %h %h",
               InstrF, PCF, PCPlus4F, NOP_INSTR, RST_PC, RST_PC + 32'd4);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = RST_PC;
    fetch_exp = RST_PC;
    rsp_due = -1;
    cycle(1'b0, 1'b0, '0);
    tests_run++;
    if (s_req !== 1'b1 || s_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1 %h", s_req, s_addr, RST_PC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a_addr [5];
    logic        a_vld  [5];
    logic [31:0] a_pc   [5];
    apply_reset();
    k_lo = 1; k_hi = 1; gnt_pct = 100;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0);
      a_addr[i] = s_gnt ? s_addr : 32'hFFFF_FFFF;
      a_vld[i] = s_vld;
      a_pc[i] = s_pcf;
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (a_addr[i] !== 32'(i * 4)) begin
        tests_failed++;
        $display("FAIL basic_addr%0d: granted addr=%h, want %h", i, a_addr[i], 32'(i * 4));
      end
    end
    tests_run++;
    if (a_vld[0] !== 1'b0 || a_vld[1] !== 1'b0 || a_vld[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: vld=%b%b%b, want 001", a_vld[0], a_vld[1], a_vld[2]);
    end
    for (int i = 2; i < 5; i++) begin
      tests_run++;
      if (a_vld[i] !== 1'b1 || a_pc[i] !== 32'((i - 2) * 4)) begin
        tests_failed++;
        $display("FAIL basic_pc%0d: vld=%b pc=%h, want 1 %h", i, a_vld[i], a_pc[i], 32'((i - 2) * 4));
      end
    end
  endtask

  task automatic test_stall();
    int inflight;
    repeat (2) cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      inflight = int'((fetch_exp - exp_pc) >> 2);
      cycle(1'b1, 1'b0, '0);
      tests_run++;
      if (s_req !== (inflight < DEPTH)) begin
        tests_failed++;
        $display("FAIL stall_req%0d: req=%b, want %b (in flight %0d)", i, s_req, inflight < DEPTH, inflight);
      end
    end
    repeat (6) cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_redirect_outstanding();
    k_lo = 3; k_hi = 3;
    wait_grant("redir_out");
    cycle(1'b0, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, '0);
      tests_run++;
      if (s_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL redir_out_hold%0d: req=%b, want 0", i, s_req);
      end
    end
    cycle(1'b0, 1'b0, '0);
    tests_run++;
    if (s_gnt !== 1'b1 || s_addr !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL redir_out_target_req: gnt=%b addr=%h, want 1 00000100", s_gnt, s_addr);
    end
    wait_valid_pc("redir_out", 32'h0000_0100);
  endtask

  task automatic test_redirect_with_rvalid();
    k_lo = 2; k_hi = 2;
    wait_grant("redir_rv");
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h0000_0200);
    cycle(1'b0, 1'b0, '0);
    tests_run++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_0200) begin
      tests_failed++;
      $display("FAIL redir_rv_next_req: req=%b addr=%h, want 1 00000200", s_req, s_addr);
    end
    wait_valid_pc("redir_rv", 32'h0000_0200);
  endtask

  task automatic test_gnt_withheld();
    apply_reset();
    k_lo = 1; k_hi = 1; gnt_pct = 100;
    repeat (2) cycle(1'b0, 1'b0, '0);
    gnt_pct = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0);
      tests_run++;
      if (s_addr !== 32'h8) begin
        tests_failed++;
        $display("FAIL gnt_hold%0d: addr=%h, want 00000008", i, s_addr);
      end
    end
    gnt_pct = 100;
    cycle(1'b0, 1'b0, '0);
    tests_run++;
    if (s_gnt !== 1'b1 || s_addr !== 32'h8) begin
      tests_failed++;
      $display("FAIL gnt_release: gnt=%b addr=%h, want 1 00000008", s_gnt, s_addr);
    end
    repeat (4) cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    k_lo = 3; k_hi = 3;
    wait_grant("rst_mid");
    cycle(1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (imem.IMemReq !== 1'b0 || ValidF !== 1'b0 || PCF !== RST_PC || InstrF !== NOP_INSTR) begin
      tests_failed++;
      $display("FAIL rst_mid_async: req=%b vld=%b pc=%h instr=%h, want 0 0 %h %h",
               imem.IMemReq, ValidF, PCF, InstrF, RST_PC, NOP_INSTR);
    end
    imem.IMemRValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = RST_PC;
    fetch_exp = RST_PC;
    rsp_due = cyc;
    rsp_addr = 32'hDEAD_BEE0;
    cycle(1'b0, 1'b0, '0);
    tests_run++;
    if (s_gnt !== 1'b1 || s_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL rst_mid_restart: gnt=%b addr=%h, want 1 %h", s_gnt, s_addr, RST_PC);
    end
    cycle(1'b0, 1'b0, '0);
    tests_run++;
    if (s_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_stray: vld=%b, want 0", s_vld);
    end
    wait_valid_pc("rst_mid", RST_PC);
  endtask

  task automatic test_random();
    logic st, rd;
    logic [31:0] tgt;
    k_lo = 1; k_hi = 4; gnt_pct = 60;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(3) == 0);
      rd = ($urandom_range(24) == 0) || (i == 200);
      tgt = (i == 200) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cycle(st, rd, tgt);
    end
    k_lo = 1; k_hi = 1; gnt_pct = 100;
    repeat (10) cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    imem.IMemGnt = 1'b0;
    imem.IMemRValid = 1'b0;
    imem.IMemRData = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_outstanding();
    test_redirect_with_rvalid();
    test_gnt_withheld();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
